// File: rtl/midi_pkg.sv
// Shared MIDI link definitions: status nibbles, 8N1 frame constants and the
// transmit state encoding.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

  localparam logic START_LEVEL    = 1'b0;
  localparam logic STOP_LEVEL     = 1'b1;
  localparam int   BITS_PER_FRAME = 10;
  localparam int   BYTES_PER_MSG  = 3;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } tx_state_e;

  function automatic logic [7:0] status_byte(input logic note_on,
                                             input logic [3:0] channel);
    return {(note_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), channel};
  endfunction

endpackage

// File: rtl/midi_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses TICK on the
// terminal count. Held at zero while disabled so every frame starts aligned.
module midi_baud_tick #(
  parameter int CLKS_PER_BIT = 128
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign TICK = EN && (cnt == TERMINAL);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (!EN || TICK) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/midi_transmitter.sv
// MIDI note-on/off transmitter: latches one three-byte message on START and
// sends it as three 8N1 frames on an idle-high, flop-driven line.
module midi_transmitter
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 128,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       NOTE_ON,
  input  logic [3:0] CHANNEL,
  input  logic [6:0] NOTE,
  input  logic [6:0] VELOCITY,
  output logic       DATA,
  output logic       BUSY,
  output logic       DONE,
  output tx_state_e  STATE
);

  // Handshake: START is taken on a rising edge while the FSM is IDLE, or on the
  // edge that ends the final stop bit (back-to-back, no idle gap). BUSY is high
  // from the edge after acceptance until the message ends; DONE is a one-cycle
  // pulse on that last edge. START and field inputs are ignored otherwise.

  localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_FRAME - 3);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_MSG - 1);

  tx_state_e  state_q, state_n;
  logic       data_q, data_n;
  logic       done_q, done_n;
  logic [2:0] bit_q, bit_n;
  logic [1:0] byte_q, byte_n;
  logic [7:0] sh_q, sh_n;
  logic [7:0] msg_q [BYTES_PER_MSG];
  logic       load;
  logic       tick;

  midi_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK  (CLK),
    .RESET(RESET),
    .EN   (state_q != IDLE),
    .TICK (tick)
  );

  function automatic logic head_bit(input logic [7:0] b);
    return LSB_FIRST ? b[0] : b[7];
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] b);
    return LSB_FIRST ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    done_n  = 1'b0;
    bit_n   = bit_q;
    byte_n  = byte_q;
    sh_n    = sh_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        data_n = STOP_LEVEL;
        if (START) begin
          state_n = START_BIT;
          data_n  = START_LEVEL;
          byte_n  = '0;
          load    = 1'b1;
        end
      end
      START_BIT: begin
        if (tick) begin
          state_n = DATA_BITS;
          bit_n   = '0;
          data_n  = head_bit(msg_q[byte_q]);
          sh_n    = shift_out(msg_q[byte_q]);
        end
      end
      DATA_BITS: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_n = STOP_BIT;
            data_n  = STOP_LEVEL;
          end else begin
            bit_n  = bit_q + 3'd1;
            data_n = head_bit(sh_q);
            sh_n   = shift_out(sh_q);
          end
        end
      end
      STOP_BIT: begin
        if (tick) begin
          if (byte_q != LAST_BYTE) begin
            state_n = START_BIT;
            data_n  = START_LEVEL;
            byte_n  = byte_q + 2'd1;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
            data_n  = STOP_LEVEL;
            byte_n  = '0;
            if (START) begin
              state_n = START_BIT;
              data_n  = START_LEVEL;
              load    = 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        data_n  = STOP_LEVEL;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      data_q  <= STOP_LEVEL;
      done_q  <= 1'b0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      for (int i = 0; i < BYTES_PER_MSG; i++) msg_q[i] <= '0;
    end else begin
      state_q <= state_n;
      data_q  <= data_n;
      done_q  <= done_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      sh_q    <= sh_n;
      if (load) begin
        msg_q[0] <= status_byte(NOTE_ON, CHANNEL);
        msg_q[1] <= {1'b0, NOTE};
        msg_q[2] <= {1'b0, VELOCITY};
      end
    end
  end

  assign DATA  = data_q;
  assign BUSY  = (state_q != IDLE);
  assign DONE  = done_q;
  assign STATE = state_q;

endmodule
